// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
// Central stall/flush controller for an in-order pipeline. It sits beside the
// pipeline and drives the enable (stall), NOP-insert (bubble) and clear (flush)
// of every inter-stage register. Index 0 is the pc register; a higher index is
// later in the pipe.
//
// Three sources are combined:
//   - stall_req     : per-stage combinational stall requests
//   - counted hold  : a multi-cycle hold (divider, cache refill) owned by one
//                     stage and lasting exactly hold_cycles cycles
//   - flush_req     : branch/exception flush from stage FLUSH_STAGE, which
//                     clears stages 0..FLUSH_STAGE-1 once that stage can move
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   stall_req         per-stage stall requests (level)
//   hold_start        pulse starting a counted hold
//   hold_stage        stage index owning the hold (sampled with hold_start)
//   hold_cycles       hold length in cycles (sampled with hold_start)
//   flush_req         one-cycle flush request
//   stall             bit i: register i keeps its value
//   bubble            bit i: register i loads a NOP
//   flush             bit i: register i is cleared this cycle
//   hold_busy         a counted hold is running; new hold_start is ignored
//   flush_pending     a flush was accepted but is waiting for its stage
//
// Optional feature (macro STALL_PERF_EN): adds stall_cycles (32 bit) and
// flush_count (16 bit) performance counters. With the macro undefined the
// ports and counters do not exist.

module pipeline_stall_ctrl #(
  parameter int NUM_STAGES  = 6,
  parameter int FLUSH_STAGE = 3,
  parameter int STAGE_W     = 3,
  parameter int CNT_W       = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic                  hold_start,
  input  logic [STAGE_W-1:0]    hold_stage,
  input  logic [CNT_W-1:0]      hold_cycles,
  input  logic                  flush_req,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] bubble,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  hold_busy,
`ifdef STALL_PERF_EN
  output logic [31:0]           stall_cycles,
  output logic [15:0]           flush_count,
`endif
  output logic                  flush_pending
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        remaining_q, remaining_d;
  logic [STAGE_W-1:0]      held_stage_q, held_stage_d;
  logic                    hold_busy_q, hold_busy_d;
  logic                    flush_pending_q, flush_pending_d;

  logic                    hold_accept;
  logic                    hold_active;
  logic [STAGE_W-1:0]      hold_idx;
  logic [NUM_STAGES-1:0]   hold_vec;
  logic [NUM_STAGES-1:0]   eff;

  logic                    eff_any;
  int                      top_idx;
  logic [NUM_STAGES-1:0]   stall_raw;
  logic [NUM_STAGES-1:0]   bubble_raw;
  logic [NUM_STAGES-1:0]   flush_mask;
  logic                    flush_trig;
  logic                    flush_apply;

`ifdef STALL_PERF_EN
  logic [31:0]             stall_cycles_q, stall_cycles_d;
  logic [15:0]             flush_count_q, flush_count_d;
`endif

  // A hold is accepted only from IDLE with a non-zero length and a stage that
  // exists; it contributes to the request vector in the acceptance cycle too,
  // which is why the hold index comes straight from the inputs in that cycle.
  always_comb begin
    hold_accept = (state_q == IDLE) && hold_start && (hold_cycles != '0)
                  && (int'(hold_stage) < NUM_STAGES);
    hold_active = (state_q == HOLD) || hold_accept;
    hold_idx    = (state_q == HOLD) ? held_stage_q : hold_stage;
    hold_vec    = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      hold_vec[i] = hold_active && (i == int'(hold_idx));
    end
    eff = stall_req | hold_vec;
  end

  // The latest stalled stage freezes itself and everything in front of it;
  // the register just behind it gets a bubble so nothing is duplicated.
  // A flush can only fire when stage FLUSH_STAGE and later are free to move,
  // i.e. the latest stalled stage is before the flushing stage.
  always_comb begin
    eff_any    = 1'b0;
    top_idx    = 0;
    stall_raw  = '0;
    bubble_raw = '0;
    flush_mask = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (eff[i]) begin
        eff_any = 1'b1;
        top_idx = i;
      end
    end
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (eff_any && (i <= top_idx)) stall_raw[i] = 1'b1;
      if (eff_any && (i == top_idx + 1)) bubble_raw[i] = 1'b1;
      if (i < FLUSH_STAGE) flush_mask[i] = 1'b1;
    end
    flush_trig  = flush_req || flush_pending_q;
    flush_apply = flush_trig && (!eff_any || (top_idx < FLUSH_STAGE));
  end

  // Hold counter: remaining counts the cycles still owed after the current one.
  // An applied flush cancels a hold owned by a stage it is about to clear,
  // since that instruction is being discarded anyway.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    held_stage_d = held_stage_q;
    case (state_q)
      IDLE: begin
        if (hold_accept && (hold_cycles != CNT_W'(1))) begin
          state_d      = HOLD;
          remaining_d  = hold_cycles - CNT_W'(1);
          held_stage_d = hold_stage;
        end
      end
      HOLD: begin
        if (flush_apply && (int'(held_stage_q) < FLUSH_STAGE)) begin
          state_d     = IDLE;
          remaining_d = '0;
        end else if (remaining_q == CNT_W'(1)) begin
          state_d     = IDLE;
          remaining_d = '0;
        end else begin
          remaining_d = remaining_q - CNT_W'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        remaining_d = '0;
      end
    endcase
    hold_busy_d     = (state_d == HOLD);
    flush_pending_d = flush_trig && !flush_apply;
  end

`ifdef STALL_PERF_EN
  // Counters wrap naturally at all-ones.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (eff_any && !flush_apply) stall_cycles_d = stall_cycles_q + 32'd1;
    if (flush_apply) flush_count_d = flush_count_q + 16'd1;
  end
`endif

  // All state, including the registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      remaining_q     <= '0;
      held_stage_q    <= '0;
      hold_busy_q     <= 1'b0;
      flush_pending_q <= 1'b0;
`ifdef STALL_PERF_EN
      stall_cycles_q  <= '0;
      flush_count_q   <= '0;
`endif
    end else begin
      state_q         <= state_d;
      remaining_q     <= remaining_d;
      held_stage_q    <= held_stage_d;
      hold_busy_q     <= hold_busy_d;
      flush_pending_q <= flush_pending_d;
`ifdef STALL_PERF_EN
      stall_cycles_q  <= stall_cycles_d;
      flush_count_q   <= flush_count_d;
`endif
    end
  end

  // Flush wins over stall/bubble on the cleared registers; combinational
  // outputs are held at 0 throughout reset.
  always_comb begin
    stall  = '0;
    bubble = '0;
    flush  = '0;
    if (!rst) begin
      if (flush_apply) begin
        flush  = flush_mask;
        stall  = stall_raw & ~flush_mask;
        bubble = bubble_raw & ~flush_mask;
      end else begin
        stall  = stall_raw;
        bubble = bubble_raw;
      end
    end
  end

  assign hold_busy     = hold_busy_q;
  assign flush_pending = flush_pending_q;
`ifdef STALL_PERF_EN
  assign stall_cycles  = stall_cycles_q;
  assign flush_count   = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Testbench for pipeline_stall_ctrl with default parameters (6 stages,
// flush from stage 3). A behavioural model tracks the hold as a count of
// owed cycles and the flush as a pending bit, and every cycle its expected
// stall/bubble/flush/status values are compared with the DUT. Directed steps
// additionally pin hand-computed literal values.

module tb_pipeline_stall_ctrl;

  localparam int NS = 6;
  localparam int FS = 3;

  logic          clk;
  logic          rst;
  logic [NS-1:0] stall_req;
  logic          hold_start;
  logic [2:0]    hold_stage;
  logic [5:0]    hold_cycles;
  logic          flush_req;
  logic [NS-1:0] stall;
  logic [NS-1:0] bubble;
  logic [NS-1:0] flush;
  logic          hold_busy;
  logic          flush_pending;
`ifdef STALL_PERF_EN
  logic [31:0]   stall_cycles;
  logic [15:0]   flush_count;
`endif

  int asserts  = 0;
  int failures = 0;

  pipeline_stall_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stall_req    (stall_req),
    .hold_start   (hold_start),
    .hold_stage   (hold_stage),
    .hold_cycles  (hold_cycles),
    .flush_req    (flush_req),
    .stall        (stall),
    .bubble       (bubble),
    .flush        (flush),
    .hold_busy    (hold_busy),
`ifdef STALL_PERF_EN
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count),
`endif
    .flush_pending(flush_pending)
  );

  // 10 ns clock, first rising edge at 5 ns.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owed hold cycles, owning stage, pending flush, counters.
  int          mHoldLeft   = 0;
  int          mHeldStage  = 0;
  bit          mPend       = 1'b0;
  int unsigned mStallCyc   = 0;
  int unsigned mFlushCnt   = 0;

  // Inputs change shortly after the rising edge; the model is evaluated and
  // compared on the falling edge, then advanced to the next cycle.
  always @(negedge clk) begin
    logic [NS-1:0] effM, expStall, expBubble, expFlush;
    int  top;
    bit  startBusy, accept, trig, apply;
    if (rst) begin
      checkVal("rst_stall", 32'(stall), 32'd0);
      checkVal("rst_bubble", 32'(bubble), 32'd0);
      checkVal("rst_flush", 32'(flush), 32'd0);
      checkVal("rst_busy", 32'(hold_busy), 32'd0);
      checkVal("rst_pend", 32'(flush_pending), 32'd0);
      mHoldLeft = 0; mHeldStage = 0; mPend = 1'b0; mStallCyc = 0; mFlushCnt = 0;
    end else begin
      startBusy = (mHoldLeft > 0);
      accept = !startBusy && hold_start && (hold_cycles != 0) && (int'(hold_stage) < NS);
      if (accept) begin
        mHoldLeft  = int'(hold_cycles);
        mHeldStage = int'(hold_stage);
      end
      effM = stall_req;
      if (mHoldLeft > 0) effM[mHeldStage] = 1'b1;
      top = -1;
      for (int i = 0; i < NS; i++) if (effM[i]) top = i;
      expStall  = (top < 0) ? '0 : NS'((1 << (top + 1)) - 1);
      expBubble = (top >= 0 && top < NS - 1) ? NS'(1 << (top + 1)) : '0;
      trig  = flush_req || mPend;
      apply = trig && (top < FS);
      expFlush = apply ? NS'((1 << FS) - 1) : '0;
      expStall  = expStall & ~expFlush;
      expBubble = expBubble & ~expFlush;
      checkVal("model_stall", 32'(stall), 32'(expStall));
      checkVal("model_bubble", 32'(bubble), 32'(expBubble));
      checkVal("model_flush", 32'(flush), 32'(expFlush));
      checkVal("model_busy", 32'(hold_busy), 32'(startBusy));
      checkVal("model_pend", 32'(flush_pending), 32'(mPend));
`ifdef STALL_PERF_EN
      checkVal("model_stall_cycles", stall_cycles, mStallCyc);
      checkVal("model_flush_count", 32'(flush_count), mFlushCnt & 32'hFFFF);
      if (top >= 0 && !apply) mStallCyc++;
      if (apply) mFlushCnt++;
`endif
      if (mHoldLeft > 0) mHoldLeft--;
      if (apply && startBusy && mHeldStage < FS) mHoldLeft = 0;
      mPend = trig && !apply;
    end
  end

  // Drive one cycle's inputs (called just after a rising edge) and let them settle.
  task automatic applyStimulus(input logic [NS-1:0] sr, input logic hs, input logic [2:0] stg,
                               input logic [5:0] cyc, input logic fr);
    stall_req   = sr;
    hold_start  = hs;
    hold_stage  = stg;
    hold_cycles = cyc;
    flush_req   = fr;
    #2;
  endtask

  // Compare outputs against hand-computed literals for this cycle.
  task automatic checkOutput(input string name, input logic [NS-1:0] eS, input logic [NS-1:0] eB,
                             input logic [NS-1:0] eF, input logic eBusy, input logic ePend);
    checkVal({name, "_stall"}, 32'(stall), 32'(eS));
    checkVal({name, "_bubble"}, 32'(bubble), 32'(eB));
    checkVal({name, "_flush"}, 32'(flush), 32'(eF));
    checkVal({name, "_busy"}, 32'(hold_busy), 32'(eBusy));
    checkVal({name, "_pend"}, 32'(flush_pending), 32'(ePend));
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(6'b0, 1'b0, 3'd0, 6'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    stall_req = '0; hold_start = 1'b0; hold_stage = '0; hold_cycles = '0; flush_req = 1'b0;
    nextCycle();
    applyStimulus(6'b111111, 1'b0, 3'd0, 6'd0, 1'b1);
    checkOutput("in_reset", 6'b0, 6'b0, 6'b0, 1'b0, 1'b0);
    nextCycle();
    rst = 1'b0;

    // Plain stall requests.
    applyStimulus(6'b010000, 1'b0, 3'd0, 6'd0, 1'b0);
    checkOutput("req4", 6'b011111, 6'b100000, 6'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(6'b000101, 1'b0, 3'd0, 6'd0, 1'b0);
    checkOutput("req2_0", 6'b000111, 6'b001000, 6'b0, 1'b0, 1'b0);
    nextCycle();

    // Counted hold on stage 3 for 4 cycles; a second start in cycle 2 is ignored.
    applyStimulus(6'b0, 1'b1, 3'd3, 6'd4, 1'b0);
    checkOutput("hold_c1", 6'b001111, 6'b010000, 6'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(6'b0, 1'b1, 3'd5, 6'd9, 1'b0);
    checkOutput("hold_c2", 6'b001111, 6'b010000, 6'b0, 1'b1, 1'b0);
    nextCycle();
    idle();
    checkOutput("hold_c3", 6'b001111, 6'b010000, 6'b0, 1'b1, 1'b0);
    nextCycle();
    idle();
    checkOutput("hold_c4", 6'b001111, 6'b010000, 6'b0, 1'b1, 1'b0);
    nextCycle();
    idle();
    checkOutput("hold_done", 6'b0, 6'b0, 6'b0, 1'b0, 1'b0);
    nextCycle();

    // Zero-length and out-of-range holds are ignored.
    applyStimulus(6'b0, 1'b1, 3'd4, 6'd0, 1'b0);
    checkOutput("hold_zero", 6'b0, 6'b0, 6'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(6'b0, 1'b1, 3'd6, 6'd3, 1'b0);
    checkOutput("hold_range", 6'b0, 6'b0, 6'b0, 1'b0, 1'b0);
    nextCycle();
    idle();
    checkOutput("hold_range_after", 6'b0, 6'b0, 6'b0, 1'b0, 1'b0);
    nextCycle();

    // Flush applied immediately, then a deferred flush.
    applyStimulus(6'b000010, 1'b0, 3'd0, 6'd0, 1'b1);
    checkOutput("flush_now", 6'b0, 6'b0, 6'b000111, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(6'b010000, 1'b0, 3'd0, 6'd0, 1'b1);
    checkOutput("flush_defer", 6'b011111, 6'b100000, 6'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(6'b010000, 1'b0, 3'd0, 6'd0, 1'b1);
    checkOutput("flush_wait", 6'b011111, 6'b100000, 6'b0, 1'b0, 1'b1);
    nextCycle();
    idle();
    checkOutput("flush_late", 6'b0, 6'b0, 6'b000111, 1'b0, 1'b1);
    nextCycle();
    idle();
    checkOutput("flush_once", 6'b0, 6'b0, 6'b0, 1'b0, 1'b0);
    nextCycle();

    // Hold on stage 1 cancelled by a flush in its third cycle.
    applyStimulus(6'b0, 1'b1, 3'd1, 6'd10, 1'b0);
    checkOutput("hc_c1", 6'b000011, 6'b000100, 6'b0, 1'b0, 1'b0);
    nextCycle();
    idle();
    checkOutput("hc_c2", 6'b000011, 6'b000100, 6'b0, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(6'b0, 1'b0, 3'd0, 6'd0, 1'b1);
    checkOutput("hc_c3", 6'b0, 6'b0, 6'b000111, 1'b1, 1'b0);
    nextCycle();
    idle();
    checkOutput("hc_c4", 6'b0, 6'b0, 6'b0, 1'b0, 1'b0);
    nextCycle();

    // Hold on stage 4 is not cancelled; the flush waits for it to finish.
    applyStimulus(6'b0, 1'b1, 3'd4, 6'd3, 1'b0);
    checkOutput("h4_c1", 6'b011111, 6'b100000, 6'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(6'b0, 1'b0, 3'd0, 6'd0, 1'b1);
    checkOutput("h4_c2", 6'b011111, 6'b100000, 6'b0, 1'b1, 1'b0);
    nextCycle();
    idle();
    checkOutput("h4_c3", 6'b011111, 6'b100000, 6'b0, 1'b1, 1'b1);
    nextCycle();
    idle();
    checkOutput("h4_flush", 6'b0, 6'b0, 6'b000111, 1'b0, 1'b1);
    nextCycle();
    idle();
    checkOutput("h4_clear", 6'b0, 6'b0, 6'b0, 1'b0, 1'b0);
    nextCycle();

    // Reset in the middle of a hold with a flush pending.
    applyStimulus(6'b0, 1'b1, 3'd4, 6'd10, 1'b0);
    nextCycle();
    applyStimulus(6'b0, 1'b0, 3'd0, 6'd0, 1'b1);
    nextCycle();
    idle();
    checkOutput("pre_rst", 6'b011111, 6'b100000, 6'b0, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst", 6'b0, 6'b0, 6'b0, 1'b0, 1'b0);
`ifdef STALL_PERF_EN
    checkVal("rst_stall_cycles", stall_cycles, 32'd0);
    checkVal("rst_flush_count", 32'(flush_count), 32'd0);
`endif
    nextCycle();
    rst = 1'b0;
    idle();
    checkOutput("post_rst", 6'b0, 6'b0, 6'b0, 1'b0, 1'b0);
    nextCycle();
    idle();
    checkOutput("post_rst2", 6'b0, 6'b0, 6'b0, 1'b0, 1'b0);
    nextCycle();

    // Mixed traffic checked by the model alone.
    for (int n = 0; n < 60; n++) begin
      logic fr;
      logic hs;
      fr = ($urandom_range(0, 3) == 0);
      hs = !fr && !flush_pending && ($urandom_range(0, 4) == 0);
      applyStimulus(NS'($urandom_range(0, 63) & $urandom_range(0, 63)), hs,
                    3'($urandom_range(0, 7)), 6'($urandom_range(0, 5)), fr);
      nextCycle();
    end
    idle();
    repeat (12) nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Parametrised successor to the fixed six-stage stall controller.
- Combines per-stage stall requests, a counted multi-cycle hold (divider, cache refill) and a branch/exception flush.
- Produces per-stage stall, bubble and flush vectors for the pipeline registers.
- Sits beside the pipeline and drives the enable/clear of every inter-stage register.

Parameters:
- NUM_STAGES, 6: number of pipeline registers controlled; index 0 is the pc register, higher index is later in the pipe.
- FLUSH_STAGE, 3: index of the stage issuing flush_req; a flush clears stages 0..FLUSH_STAGE-1.
- STAGE_W, 3: width of hold_stage; must satisfy 2^STAGE_W >= NUM_STAGES.
- CNT_W, 6: width of the hold cycle counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- stall_req  in  NUM_STAGES  bit i = stage i requests a stall this cycle (level, combinational)
- hold_start  in  1  one-cycle pulse to start a counted hold
- hold_stage  in  STAGE_W  stage index owning the hold; sampled with hold_start
- hold_cycles  in  CNT_W  hold length in cycles; sampled with hold_start
- flush_req  in  1  one-cycle flush request from stage FLUSH_STAGE
- stall  out  NUM_STAGES  bit i = register i holds its value
- bubble  out  NUM_STAGES  bit i = register i loads a NOP
- flush  out  NUM_STAGES  bit i = register i cleared this cycle
- hold_busy  out  1  counted hold in progress; new hold_start is ignored
- flush_pending  out  1  flush accepted but deferred

Behaviour:
- Reset, asynchronous:
  - State goes to IDLE; counter, pending flag and every registered output clear to 0.
  - Combinational outputs read 0 while rst is high.
  - A reset mid-hold or mid-pending aborts it with no residual effect.
- Effective request vector: eff = stall_req | hold_vec.
  - hold_vec has bit hold_stage set while a hold is active, including the hold_start cycle if accepted.
- Stall vector: let k be the highest set index of eff.
  - stall[0..k] = 1 and all other stall bits are 0.
  - bubble[k+1] = 1 if k+1 < NUM_STAGES; all other bubble bits are 0.
  - If eff is 0, stall and bubble are all 0.
- Hold FSM, states IDLE and HOLD:
  - IDLE + hold_start, with hold_cycles != 0 and hold_stage < NUM_STAGES: the hold is accepted and applies in that same cycle.
  - On acceptance, if hold_cycles == 1, stay IDLE. Otherwise go to HOLD with remaining = hold_cycles-1.
  - HOLD: hold_vec is active. remaining decrements every cycle; when remaining == 1, return to IDLE next cycle.
  - The total stall contribution is exactly hold_cycles cycles.
  - hold_start with hold_cycles == 0 or an out-of-range stage is ignored.
  - hold_start while HOLD is ignored; hold_busy = (state == HOLD).
  - Other stall_req bits do not pause the counter.
- Flush:
  - Trigger: flush_req or flush_pending is set.
  - Applied when k < FLUSH_STAGE or eff == 0:
    - flush[0..FLUSH_STAGE-1] = 1 in that cycle.
    - stall and bubble are forced to 0 for those bits; flush wins over stall.
    - flush_pending clears next cycle.
  - Deferred when k >= FLUSH_STAGE (the flushing stage is itself stalled): flush is 0 and flush_pending sets next cycle.
  - Repeat flush_req while pending merges into one flush and is not counted twice.
  - A flush applied while HOLD is active with the held stage < FLUSH_STAGE cancels the hold.
    - The hold goes to IDLE next cycle; hold_vec is still honoured for stall in the flush cycle, but flush overrides it.
  - If HOLD is active with the held stage >= FLUSH_STAGE, the hold continues.
- flush bits >= FLUSH_STAGE are never set.

Optional Feature:
- Macro STALL_PERF_EN.
- Defined: adds ports stall_cycles (out, 32) and flush_count (out, 16), both reset to 0.
  - stall_cycles increments each cycle eff != 0 and no flush is applied.
  - flush_count increments once per applied flush.
  - Both wrap at all-ones to 0.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- stall_req=6'b010000, no hold/flush -> stall=6'b011111, bubble=6'b100000, flush=0.
- stall_req=6'b000100 and 6'b000001 together -> k=2: stall=6'b000111, bubble=6'b001000.
- hold_start, hold_stage=3, hold_cycles=4, then idle -> stall=6'b001111 for exactly 4 cycles from the start cycle; hold_busy high cycles 2-4; hold_start in cycle 2 ignored; hold_cycles=0 produces no stall.
- flush_req with stall_req=6'b000010 -> same cycle flush=6'b000111, stall=0; with stall_req=6'b010000 -> flush=0, flush_pending=1; after stall_req drops -> flush=6'b000111 once, flush_pending then 0.
- hold on stage 1 (hold_cycles=10), flush_req at cycle 3 -> flush=6'b000111 in cycle 3, hold_busy=0 from cycle 4, stall=0 after.
- rst asserted mid-HOLD with flush_pending=1 -> all outputs 0 immediately; after release stall=0 with no residual flush; with STALL_PERF_EN, counters read 0.
